// File: rtl/axi_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : axi_fifo_wr_arb
// Purpose  : Two-requester AXI write-channel arbiter in front of axi_fifo.
//            Exactly one write transaction (AW, W burst, B) is in flight at
//            a time. Round-robin grant is taken in IDLE and held until the
//            B handshake completes. The forwarded m_wlast is generated from
//            the captured awlen; a requester wlast that disagrees with it
//            raises the sticky proto_err flag.
// Ports    :
//   clk, rst                     clock / asynchronous active-high reset
//   s_awvalid/s_awready/s_aw     per-requester AW channel (2 lanes, packed)
//   s_wvalid/s_wready/s_wdata/
//   s_wstrb/s_wlast              per-requester W channel (2 lanes, packed)
//   s_bvalid/s_bready            per-requester B handshake
//   s_bid/s_bresp                shared B payload (qualified by s_bvalid)
//   m_aw/m_awvalid/m_awready     AW channel toward axi_fifo
//   m_wdata/m_wstrb/m_wlast/
//   m_wvalid/m_wready            W channel toward axi_fifo
//   m_bid/m_bresp/m_bvalid/
//   m_bready                     B channel from axi_fifo
//   proto_err                    sticky requester wlast/awlen disagreement
// AW lane packing: {awid, awaddr, awlen[7:0], awsize[2:0], awburst[1:0],
//                   awcache[3:0]}
// Revision : 1.0  initial release
// ============================================================================
module axi_fifo_wr_arb #(
  parameter  int ID_W   = 8,
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8,
  localparam int AW_W   = ID_W + ADDR_W + 17
) (
  input  logic                  clk,
  input  logic                  rst,
  // requester AW
  input  logic [1:0]            s_awvalid,
  output logic [1:0]            s_awready,
  input  logic [2*AW_W-1:0]     s_aw,
  // requester W
  input  logic [1:0]            s_wvalid,
  output logic [1:0]            s_wready,
  input  logic [2*DATA_W-1:0]   s_wdata,
  input  logic [2*STRB_W-1:0]   s_wstrb,
  input  logic [1:0]            s_wlast,
  // requester B
  output logic [1:0]            s_bvalid,
  input  logic [1:0]            s_bready,
  output logic [ID_W-1:0]       s_bid,
  output logic [1:0]            s_bresp,
  // downstream AW
  output logic [AW_W-1:0]       m_aw,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  // downstream W
  output logic [DATA_W-1:0]     m_wdata,
  output logic [STRB_W-1:0]     m_wstrb,
  output logic                  m_wlast,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  // downstream B
  input  logic [ID_W-1:0]       m_bid,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  // status
  output logic                  proto_err
);

  // awlen sits above awcache[3:0], awburst[1:0], awsize[2:0]
  localparam int AWLEN_LSB = 9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      state_q,      state_d;
  logic        grant_q,      grant_d;
  logic        last_grant_q, last_grant_d;
  logic [7:0]  awlen_q,      awlen_d;
  logic [7:0]  beat_cnt_q,   beat_cnt_d;
  logic        proto_err_q,  proto_err_d;

  logic        last_beat;
  logic        aw_hs;
  logic        w_hs;
  logic        b_hs;

  // --------------------------------------------------------------------------
  // Payload muxes. These are steered by the held grant in every state; the
  // matching valid/ready qualifiers below decide whether they mean anything.
  // --------------------------------------------------------------------------
  assign m_aw    = grant_q ? s_aw[AW_W +: AW_W]        : s_aw[0 +: AW_W];
  assign m_wdata = grant_q ? s_wdata[DATA_W +: DATA_W] : s_wdata[0 +: DATA_W];
  assign m_wstrb = grant_q ? s_wstrb[STRB_W +: STRB_W] : s_wstrb[0 +: STRB_W];
  assign s_bid   = m_bid;
  assign s_bresp = m_bresp;

  assign proto_err = proto_err_q;

  // Burst length is owned by the captured awlen, never by requester wlast.
  assign last_beat = (beat_cnt_q == awlen_q);

  assign aw_hs = (state_q == S_ADDR) && s_awvalid[grant_q] && m_awready;
  assign w_hs  = (state_q == S_DATA) && s_wvalid[grant_q]  && m_wready;
  assign b_hs  = (state_q == S_RESP) && m_bvalid && s_bready[grant_q];

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;    // requester 0 wins the first contention
      awlen_q      <= 8'd0;
      beat_cnt_q   <= 8'd0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      awlen_q      <= awlen_d;
      beat_cnt_q   <= beat_cnt_d;
      proto_err_q  <= proto_err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and handshake steering. All valid/ready outputs derive only
  // from state_q, so an asynchronous reset drops them in the same cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    awlen_d      = awlen_q;
    beat_cnt_d   = beat_cnt_q;
    proto_err_d  = proto_err_q;

    s_awready    = 2'b00;
    s_wready     = 2'b00;
    s_bvalid     = 2'b00;
    m_awvalid    = 1'b0;
    m_wvalid     = 1'b0;
    m_wlast      = 1'b0;
    m_bready     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|s_awvalid) begin
          // On contention the requester that was not served last wins;
          // otherwise the only requester present is granted.
          if (&s_awvalid) begin
            grant_d = ~last_grant_q;
          end else begin
            grant_d = s_awvalid[1];
          end
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        m_awvalid           = s_awvalid[grant_q];
        s_awready[grant_q]  = m_awready;
        if (aw_hs) begin
          awlen_d    = m_aw[AWLEN_LSB +: 8];
          beat_cnt_d = 8'd0;
          state_d    = S_DATA;
        end
      end

      S_DATA: begin
        m_wvalid           = s_wvalid[grant_q];
        m_wlast            = last_beat;
        s_wready[grant_q]  = m_wready;
        if (w_hs) begin
          // 8-bit counter wraps naturally after a 256-beat burst.
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (s_wlast[grant_q] != last_beat) begin
            proto_err_d = 1'b1;
          end
          if (last_beat) begin
            state_d = S_RESP;
          end
        end
      end

      S_RESP: begin
        s_bvalid[grant_q] = m_bvalid;
        m_bready          = s_bready[grant_q];
        if (b_hs) begin
          last_grant_d = grant_q;
          state_d      = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_fifo_wr_arb
// Purpose  : Directed self-checking bench for axi_fifo_wr_arb. Requesters
//            and the downstream fabric are driven on the falling edge and
//            outputs are checked 1 ns later, away from the rising edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_axi_fifo_wr_arb;

  localparam int ID_W   = 8;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int AW_W   = ID_W + ADDR_W + 17;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          s_awvalid;
  logic [1:0]          s_awready;
  logic [2*AW_W-1:0]   s_aw;
  logic [1:0]          s_wvalid;
  logic [1:0]          s_wready;
  logic [2*DATA_W-1:0] s_wdata;
  logic [2*STRB_W-1:0] s_wstrb;
  logic [1:0]          s_wlast;
  logic [1:0]          s_bvalid;
  logic [1:0]          s_bready;
  logic [ID_W-1:0]     s_bid;
  logic [1:0]          s_bresp;
  logic [AW_W-1:0]     m_aw;
  logic                m_awvalid;
  logic                m_awready;
  logic [DATA_W-1:0]   m_wdata;
  logic [STRB_W-1:0]   m_wstrb;
  logic                m_wlast;
  logic                m_wvalid;
  logic                m_wready;
  logic [ID_W-1:0]     m_bid;
  logic [1:0]          m_bresp;
  logic                m_bvalid;
  logic                m_bready;
  logic                proto_err;

  int errors = 0;
  int checks = 0;

  axi_fifo_wr_arb #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_aw(s_aw),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .m_aw(m_aw), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW_W-1:0] aw_pl(input int r, input logic [7:0] id,
                                             input logic [7:0] len);
    return {id, 32'h1000_0000 + 32'(r) * 32'h100, len, 3'd2, 2'b01, 4'(r + 3)};
  endfunction

  function automatic logic [DATA_W-1:0] data_pl(input int r, input int beat);
    return 32'hA000_0000 ^ (32'(r) << 20) ^ 32'(beat);
  endfunction

  function automatic logic [STRB_W-1:0] strb_pl(input int r, input int beat);
    return 4'(beat + r + 1);
  endfunction

  task automatic drive_w(input int r, input int beat);
    s_wdata[r*DATA_W +: DATA_W]         = data_pl(r, beat);
    s_wstrb[r*STRB_W +: STRB_W]         = strb_pl(r, beat);
    s_wdata[(1-r)*DATA_W +: DATA_W]     = ~data_pl(r, beat);
    s_wstrb[(1-r)*STRB_W +: STRB_W]     = ~strb_pl(r, beat);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One complete transaction for requester r. 'both' raises the other
  // requester's awvalid too (contention); bad_beat >= 0 puts the requester
  // wlast on that beat only; tog toggles m_wready; bstall holds s_bready low.
  task automatic do_txn(input int r, input bit both, input logic [7:0] len,
                        input logic [7:0] id, input int bad_beat, input bit tog,
                        input int bstall);
    int beat;
    int cyc;
    logic [1:0] rb;
    rb = 2'b01 << r;

    @(negedge clk);
    s_aw[r*AW_W +: AW_W]     = aw_pl(r, id, len);
    s_aw[(1-r)*AW_W +: AW_W] = aw_pl(1 - r, id ^ 8'h55, len ^ 8'h01);
    s_awvalid = both ? 2'b11 : rb;
    m_awready = 1'b1;
    #1;
    check("idle_awvalid", 64'(m_awvalid), 64'd0);
    check("idle_awready", 64'(s_awready), 64'd0);

    @(negedge clk);
    s_wvalid = rb;
    s_wlast  = 2'b00;
    m_wready = 1'b1;
    drive_w(r, 0);
    #1;
    check("addr_awvalid", 64'(m_awvalid), 64'd1);
    check("addr_aw", 64'(m_aw), 64'(aw_pl(r, id, len)));
    check("addr_awready", 64'(s_awready), 64'(rb));
    check("addr_wstall", 64'(s_wready), 64'd0);
    check("addr_wvalid", 64'(m_wvalid), 64'd0);

    beat = 0;
    cyc  = 0;
    while (beat <= int'(len) && cyc < 600) begin
      @(negedge clk);
      s_awvalid = 2'b00;
      m_wready  = tog ? (cyc % 2 == 0) : 1'b1;
      drive_w(r, beat);
      if (bad_beat >= 0) s_wlast = (beat == bad_beat) ? rb : 2'b00;
      else               s_wlast = (beat == int'(len)) ? rb : 2'b00;
      #1;
      check("w_valid", 64'(m_wvalid), 64'd1);
      check("w_data", 64'(m_wdata), 64'(data_pl(r, beat)));
      check("w_strb", 64'(m_wstrb), 64'(strb_pl(r, beat)));
      check("w_last", 64'(m_wlast), 64'(beat == int'(len)));
      check("w_ready", 64'(s_wready), m_wready ? 64'(rb) : 64'd0);
      if (m_wready) beat++;
      cyc++;
    end
    if (cyc >= 600) check("w_timeout", 64'd1, 64'd0);

    @(negedge clk);
    s_wvalid = 2'b00;
    s_wlast  = 2'b00;
    m_wready = 1'b0;
    m_bvalid = 1'b1;
    m_bid    = id;
    m_bresp  = id[1:0];
    s_bready = ~rb;          // the other requester being ready must not matter
    for (int k = 0; k < bstall; k++) begin
      #1;
      check("b_stall_valid", 64'(s_bvalid), 64'(rb));
      check("b_stall_ready", 64'(m_bready), 64'd0);
      @(negedge clk);
    end
    s_bready = rb;
    #1;
    check("b_valid", 64'(s_bvalid), 64'(rb));
    check("b_ready", 64'(m_bready), 64'd1);
    check("b_id", 64'(s_bid), 64'(id));
    check("b_resp", 64'(s_bresp), 64'(id[1:0]));

    @(negedge clk);
    m_bvalid = 1'b0;
    s_bready = 2'b00;
    #1;
    check("post_b_valid", 64'(s_bvalid), 64'd0);
    check("post_b_awvalid", 64'(m_awvalid), 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    s_awvalid = '0;
    s_aw      = '0;
    s_wvalid  = '0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_wlast   = '0;
    s_bready  = '0;
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_bid     = '0;
    m_bresp   = '0;
    m_bvalid  = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_awvalid", 64'(m_awvalid), 64'd0);
    check("rst_wvalid", 64'(m_wvalid), 64'd0);
    check("rst_bready", 64'(m_bready), 64'd0);
    check("rst_s_ready", 64'({s_awready, s_wready}), 64'd0);
    check("rst_bvalid", 64'(s_bvalid), 64'd0);
    check("rst_proto_err", 64'(proto_err), 64'd0);
    rst = 1'b0;

    // Single requester 0, 4-beat burst
    do_txn(0, 1'b0, 8'd3, 8'h5A, -1, 1'b0, 0);

    // Contention from reset: 0,1,0,1
    do_reset();
    do_txn(0, 1'b1, 8'd1, 8'h01, -1, 1'b0, 0);
    do_txn(1, 1'b1, 8'd1, 8'h02, -1, 1'b0, 0);
    do_txn(0, 1'b1, 8'd0, 8'h03, -1, 1'b0, 0);
    do_txn(1, 1'b1, 8'd2, 8'h04, -1, 1'b0, 0);
    check("proto_err_clean", 64'(proto_err), 64'd0);

    // Requester 1 with wlast on beat 2 of 4
    do_txn(1, 1'b0, 8'd3, 8'h7E, 1, 1'b0, 0);
    check("proto_err_set", 64'(proto_err), 64'd1);
    do_txn(0, 1'b0, 8'd2, 8'h11, -1, 1'b0, 0);
    check("proto_err_sticky", 64'(proto_err), 64'd1);

    // Toggling m_wready and 5-cycle B stall
    do_txn(0, 1'b0, 8'd5, 8'h44, -1, 1'b1, 5);

    // 256-beat burst
    do_txn(1, 1'b0, 8'd255, 8'h99, -1, 1'b0, 0);

    // Reset during second data beat of a requester 1 burst
    @(negedge clk);
    s_aw[AW_W +: AW_W] = aw_pl(1, 8'h21, 8'd3);
    s_awvalid = 2'b10;
    m_awready = 1'b1;
    @(negedge clk);
    s_wvalid = 2'b10;
    m_wready = 1'b1;
    drive_w(1, 0);
    @(negedge clk);
    s_awvalid = 2'b00;
    @(negedge clk);
    drive_w(1, 1);
    #1;
    check("pre_rst_wvalid", 64'(m_wvalid), 64'd1);
    rst      = 1'b1;
    m_bvalid = 1'b1;
    s_bready = 2'b11;
    #1;
    check("async_rst_wvalid", 64'(m_wvalid), 64'd0);
    check("async_rst_s_ready", 64'({s_awready, s_wready}), 64'd0);
    check("async_rst_bvalid", 64'(s_bvalid), 64'd0);
    check("async_rst_m_ctl", 64'({m_awvalid, m_bready}), 64'd0);
    check("async_rst_proto_err", 64'(proto_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_bvalid", 64'(s_bvalid), 64'd0);
    check("post_rst_bready", 64'(m_bready), 64'd0);
    s_wvalid = 2'b00;
    m_bvalid = 1'b0;
    s_bready = 2'b00;

    // After reset requester 0 has priority again
    do_txn(0, 1'b1, 8'd2, 8'h33, -1, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_fifo_wr_arb.md
AXI_FIFO_WR_ARB -- requirements
Module: axi_fifo_wr_arb

Interface
REQ-001 Parameter ID_W, 8, AXI ID width.
REQ-002 Parameter ADDR_W, 32, AXI address width.
REQ-003 Parameter DATA_W, 32, AXI data width; strobe width DATA_W/8; AW_W = ID_W+ADDR_W+17 (derived, not overridable).
REQ-004 The block SHALL use one clock, clk; reset rst SHALL be asynchronous and active-high.
REQ-005 clk  input  1  clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 s_awvalid  input  2  per-requester AW valid, bit n = requester n.
REQ-008 s_awready  output  2  per-requester AW ready.
REQ-009 s_aw  input  2*AW_W  requester n at [n*AW_W +: AW_W], packed {awid,awaddr,awlen[7:0],awsize[2:0],awburst[1:0],awcache[3:0]}.
REQ-010 s_wvalid  input  2  per-requester W valid.
REQ-011 s_wready  output  2  per-requester W ready.
REQ-012 s_wdata  input  2*DATA_W  per-requester write data.
REQ-013 s_wstrb  input  2*DATA_W/8  per-requester write strobes.
REQ-014 s_wlast  input  2  per-requester last-beat flag (checked only).
REQ-015 s_bvalid  output  2  per-requester B valid.
REQ-016 s_bready  input  2  per-requester B ready.
REQ-017 s_bid  output  ID_W  shared B ID, meaningful only with its s_bvalid bit.
REQ-018 s_bresp  output  2  shared B response.
REQ-019 m_aw  output  AW_W  AW payload to axi_fifo s_axi_aw* fields, same packing.
REQ-020 m_awvalid / m_awready  output / input  1 / 1  AW handshake toward axi_fifo.
REQ-021 m_wdata / m_wstrb  output  DATA_W / DATA_W/8  W payload toward axi_fifo.
REQ-022 m_wlast / m_wvalid / m_wready  output / output / input  1 each  W control toward axi_fifo.
REQ-023 m_bid / m_bresp  input  ID_W / 2  B payload from axi_fifo.
REQ-024 m_bvalid / m_bready  input / output  1 / 1  B handshake from axi_fifo.
REQ-025 proto_err  output  1  sticky flag: requester s_wlast disagreed with awlen.

Function
REQ-026 FSM states IDLE, ADDR, DATA, RESP; exactly one write transaction in flight.
REQ-027 IDLE: if any s_awvalid bit set, register grant (round-robin: on contention the requester other than last_grant wins), go ADDR next cycle; else stay.
REQ-028 ADDR: m_awvalid=s_awvalid[grant], m_aw=s_aw[grant], s_awready[grant]=m_awready; on handshake capture awlen, clear beat_cnt, go DATA.
REQ-029 DATA: m_wvalid=s_wvalid[grant], m_wdata/m_wstrb from grant, s_wready[grant]=m_wready; beat_cnt increments per W handshake.
REQ-030 m_wlast SHALL be (beat_cnt == awlen_q), independent of s_wlast; on last-beat handshake go RESP.
REQ-031 Any W handshake where s_wlast[grant] != m_wlast SHALL set proto_err (sticky until reset); burst length still follows awlen.
REQ-032 RESP: s_bvalid[grant]=m_bvalid, m_bready=s_bready[grant], s_bid=m_bid, s_bresp=m_bresp; on handshake last_grant<=grant, go IDLE.
REQ-033 Non-granted requester ready/valid outputs SHALL be 0 in every state; all m_*valid/m_bready 0 outside their state.
REQ-034 W beats offered before AW handshake SHALL be stalled (s_wready=0), not dropped.
REQ-035 Minimum latency: s_awvalid rise to m_awvalid = 1 cycle; 256-beat burst (awlen=255) SHALL wrap beat_cnt without overflow error.
REQ-036 Grant SHALL not change between IDLE exit and RESP handshake, even if granted requester deasserts valid.

Reset
REQ-037 rst high: state IDLE, last_grant=1 (requester 0 wins first), beat_cnt=0, proto_err=0, all valid/ready outputs 0 immediately.
REQ-038 Reset mid-burst SHALL abandon the transaction; no B response forwarded afterward.

Verification
REQ-039 Single req0, awlen=3, 4 beats, all readies 1 -> m_awvalid 1 cycle after s_awvalid, 4 W beats, m_wlast on 4th, s_bvalid[0] with m_bid echoed.
REQ-040 Both requesters valid from reset -> req0 served first, then req1; repeated contention alternates 0,1,0,1.
REQ-041 req1 s_wlast on beat 2 with awlen=3 -> 4 beats forwarded, m_wlast on 4th, proto_err=1 stays set.
REQ-042 m_wready toggling 1/0 and s_bready held 0 for 5 cycles -> no beat lost or duplicated; FSM holds in RESP until s_bready=1.
REQ-043 rst asserted during DATA beat 2 -> all valid/ready outputs 0 same cycle; after release, next request served from IDLE with req0 priority.
